uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver and consumes its byte output (`rx_data`, `rx_en`).
- Assembles fixed 6-byte command frames and checks their checksum.
- Presents each good frame as one register-write request (8-bit address, 16-bit data) to the video-pipeline configuration logic, using a valid/ready handshake.
- Reports checksum, inter-byte timeout and overrun errors as single-cycle pulses.

---
 rtl/uart_cmd_pkg.sv | 18 +
 rtl/uart_gap_timer.sv | 30 +++
 rtl/uart_cmd_parser.sv | 132 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command-frame parser.
package uart_cmd_pkg;

    localparam logic [7:0] HDR0      = 8'h55;
    localparam logic [7:0] HDR1      = 8'hAA;
    localparam int         FRAME_LEN = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        H1   = 3'd1,
        ADDR = 3'd2,
        DH   = 3'd3,
        DL   = 3'd4,
        CKS  = 3'd5,
        OUT  = 3'd6
    } state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts while run is high and pulses expire on the
// last allowed cycle before a frame is abandoned.
module uart_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (run)
            count <= count + W'(1);
    end

    // A strobe in the expiry cycle wins, so clear masks the pulse.
    assign expire = run & ~clear & (count == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Command-frame parser behind the UART receiver: assembles HDR0 HDR1 ADDR DH DL CKS
// frames and issues each good one as a valid/ready register-write request.
module uart_cmd_parser #(
    parameter logic [7:0]  HDR0        = uart_cmd_pkg::HDR0,
    parameter logic [7:0]  HDR1        = uart_cmd_pkg::HDR1,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_en,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic [7:0]  cfg_addr,
    output logic [15:0] cfg_data,
    output logic        err_cks,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        busy
);

    import uart_cmd_pkg::*;

    state_t     state, state_next;
    logic       rx_en_d, byte_stb;
    logic       timer_run, timer_clear, expire;
    logic [7:0] acc, addr_q, dh_q, dl_q;
    logic       cks_err_next, to_err_next, ovr_err_next, load_out;

    // rx_en_d resets high so a level already present at release is not a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rx_en_d <= 1'b1;
        else
            rx_en_d <= rx_en;
    end

    assign byte_stb    = rx_en & ~rx_en_d;
    assign timer_run   = state inside {H1, ADDR, DH, DL, CKS};
    assign timer_clear = byte_stb | ~timer_run;

    uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (timer_run),
        .clear  (timer_clear),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        cks_err_next = 1'b0;
        to_err_next  = 1'b0;
        ovr_err_next = 1'b0;
        load_out     = 1'b0;
        case (state)
            IDLE: if (byte_stb && rx_data == HDR0) state_next = H1;
            H1: begin
                if (byte_stb) begin
                    if (rx_data == HDR1)      state_next = ADDR;
                    else if (rx_data == HDR0) state_next = H1;
                    else                      state_next = IDLE;
                end
            end
            ADDR: if (byte_stb) state_next = DH;
            DH:   if (byte_stb) state_next = DL;
            DL:   if (byte_stb) state_next = CKS;
            CKS: begin
                if (byte_stb) begin
                    if (rx_data == acc) begin
                        state_next = OUT;
                        load_out   = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        cks_err_next = 1'b1;
                    end
                end
            end
            OUT: begin
                ovr_err_next = byte_stb;
                if (cfg_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (expire && !byte_stb) begin
            state_next  = IDLE;
            to_err_next = 1'b1;
        end
    end

    // Field capture, 8-bit checksum accumulation and the registered error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            addr_q      <= '0;
            dh_q        <= '0;
            dl_q        <= '0;
            cfg_addr    <= '0;
            cfg_data    <= '0;
            err_cks     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_cks     <= cks_err_next;
            err_timeout <= to_err_next;
            err_overrun <= ovr_err_next;
            if (byte_stb) begin
                case (state)
                    ADDR: begin addr_q <= rx_data; acc <= rx_data;       end
                    DH:   begin dh_q   <= rx_data; acc <= acc + rx_data; end
                    DL:   begin dl_q   <= rx_data; acc <= acc + rx_data; end
                    default: ;
                endcase
            end
            if (load_out) begin
                cfg_addr <= addr_q;
                cfg_data <= {dh_q, dl_q};
            end
        end
    end

    assign cfg_valid = (state == OUT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser, using a short gap timeout
// so the timeout cases stay fast.
module tb_uart_cmd_parser;

    localparam int TCYC = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        err_cks, err_timeout, err_overrun, busy;

    int vectors = 0;
    int miscompares = 0;

    int          n_valid = 0, n_hs = 0, n_cks = 0, n_to = 0, n_ovr = 0;
    logic [7:0]  hs_addr = '0;
    logic [15:0] hs_data = '0;
    logic        stable_ok;

    uart_cmd_parser #(.TIMEOUT_CYC(TCYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_en       (rx_en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .err_cks     (err_cks),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so a negedge sample of valid&ready is the handshake.
    always @(negedge clk) begin
        if (cfg_valid) n_valid++;
        if (cfg_valid && cfg_ready) begin
            n_hs++;
            hs_addr = cfg_addr;
            hs_data = cfg_data;
        end
        if (err_cks)     n_cks++;
        if (err_timeout) n_to++;
        if (err_overrun) n_ovr++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        n_valid = 0; n_hs = 0; n_cks = 0; n_to = 0; n_ovr = 0;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data = b;
        rx_en   = 1'b1;
        repeat (4) @(posedge clk);
        #1 rx_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] a, b, c, d, e, f);
        applyStimulus(a); applyStimulus(b); applyStimulus(c);
        applyStimulus(d); applyStimulus(e); applyStimulus(f);
    endtask

    initial begin
        rst_n = 1'b0; rx_en = 1'b1; rx_data = 8'h55; cfg_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid",   cfg_valid,   0);
        checkOutput("rst_addr",    cfg_addr,    0);
        checkOutput("rst_data",    cfg_data,    0);
        checkOutput("rst_errcks",  err_cks,     0);
        checkOutput("rst_errto",   err_timeout, 0);
        checkOutput("rst_errovr",  err_overrun, 0);
        checkOutput("rst_busy",    busy,        0);
        rst_n = 1'b1;
        idle(3);
        checkOutput("no_spurious_stb", busy, 0);
        rx_en = 1'b0;
        idle(3);

        // Good frame, ready already high
        cfg_ready = 1'b1; clearCounts();
        sendFrame(8'h55, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);
        idle(3);
        checkOutput("good_hs",     n_hs,    1);
        checkOutput("good_vcyc",   n_valid, 1);
        checkOutput("good_addr",   hs_addr, 32'h12);
        checkOutput("good_data",   hs_data, 32'h3456);
        checkOutput("good_errs",   n_cks + n_to + n_ovr, 0);
        checkOutput("good_busy",   busy,    0);

        // Backpressure with latency check
        cfg_ready = 1'b0; clearCounts();
        applyStimulus(8'h55); applyStimulus(8'hAA); applyStimulus(8'h12);
        applyStimulus(8'h34); applyStimulus(8'h56);
        rx_data = 8'h9C; rx_en = 1'b1;
        @(negedge clk);
        checkOutput("lat_before", cfg_valid, 0);
        @(negedge clk);
        checkOutput("lat_t1", cfg_valid, 1);
        stable_ok = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (i == 3) rx_en = 1'b0;
            if (!cfg_valid || cfg_addr !== 8'h12 || cfg_data !== 16'h3456) stable_ok = 1'b0;
        end
        checkOutput("bp_stable", stable_ok, 1);
        @(posedge clk);
        #1 cfg_ready = 1'b1;
        idle(3);
        checkOutput("bp_hs",     n_hs,      1);
        checkOutput("bp_vcyc",   n_valid,   21);
        checkOutput("bp_addr",   hs_addr,   32'h12);
        checkOutput("bp_data",   hs_data,   32'h3456);
        checkOutput("bp_vdone",  cfg_valid, 0);

        // Bad checksum, then a different good frame
        clearCounts();
        sendFrame(8'h55, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h9D);
        idle(2);
        checkOutput("bad_cks",  n_cks, 1);
        checkOutput("bad_hs",   n_hs,  0);
        checkOutput("bad_busy", busy,  0);
        sendFrame(8'h55, 8'hAA, 8'h7E, 8'h01, 8'h02, 8'h81);
        idle(2);
        checkOutput("after_bad_hs",   n_hs,    1);
        checkOutput("after_bad_addr", hs_addr, 32'h7E);
        checkOutput("after_bad_data", hs_data, 32'h0102);

        // Resync on 55 55 AA after noise
        clearCounts();
        applyStimulus(8'h00); applyStimulus(8'h55);
        sendFrame(8'h55, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h03);
        idle(2);
        checkOutput("resync_hs",   n_hs,    1);
        checkOutput("resync_addr", hs_addr, 32'h01);
        checkOutput("resync_data", hs_data, 32'h0002);

        // Broken header
        clearCounts();
        applyStimulus(8'h55);
        sendFrame(8'h7F, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h03);
        idle(2);
        checkOutput("badhdr_hs",   n_hs, 0);
        checkOutput("badhdr_busy", busy, 0);
        checkOutput("badhdr_errs", n_cks + n_to + n_ovr, 0);

        // Gap longer than the timeout
        clearCounts();
        applyStimulus(8'h55); applyStimulus(8'hAA); applyStimulus(8'h12);
        idle(TCYC + 10);
        applyStimulus(8'h34); applyStimulus(8'h56); applyStimulus(8'h9C);
        idle(2);
        checkOutput("to_err",  n_to, 1);
        checkOutput("to_hs",   n_hs, 0);
        checkOutput("to_busy", busy, 0);

        // Gap shorter than the timeout
        clearCounts();
        applyStimulus(8'h55); applyStimulus(8'hAA); applyStimulus(8'h12);
        idle(TCYC - 100);
        applyStimulus(8'h34); applyStimulus(8'h56); applyStimulus(8'h9C);
        idle(2);
        checkOutput("short_gap_to", n_to, 0);
        checkOutput("short_gap_hs", n_hs, 1);

        // Overrun while a request is pending
        cfg_ready = 1'b0; clearCounts();
        sendFrame(8'h55, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h9C);
        applyStimulus(8'h55);
        checkOutput("ovr_err",   n_ovr,     1);
        checkOutput("ovr_valid", cfg_valid, 1);
        checkOutput("ovr_addr",  cfg_addr,  32'h12);
        checkOutput("ovr_data",  cfg_data,  32'h3456);
        cfg_ready = 1'b1;
        idle(2);
        checkOutput("ovr_hs",   n_hs, 1);
        checkOutput("ovr_busy", busy, 0);

        // Ready and byte in the same cycle while pending
        cfg_ready = 1'b0; clearCounts();
        sendFrame(8'h55, 8'hAA, 8'h20, 8'h10, 8'h01, 8'h31);
        cfg_ready = 1'b1;
        applyStimulus(8'h55);
        checkOutput("sim_hs",   n_hs,    1);
        checkOutput("sim_ovr",  n_ovr,   1);
        checkOutput("sim_addr", hs_addr, 32'h20);
        checkOutput("sim_busy", busy,    0);

        // Reset in the middle of a frame
        cfg_ready = 1'b0; clearCounts();
        applyStimulus(8'h55); applyStimulus(8'hAA);
        applyStimulus(8'h12); applyStimulus(8'h34);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy",  busy,      0);
        checkOutput("midrst_valid", cfg_valid, 0);
        checkOutput("midrst_addr",  cfg_addr,  0);
        checkOutput("midrst_data",  cfg_data,  0);
        idle(2);
        rst_n = 1'b1;
        cfg_ready = 1'b1;
        idle(2);
        sendFrame(8'h55, 8'hAA, 8'h20, 8'h10, 8'h01, 8'h31);
        idle(2);
        checkOutput("postrst_hs",   n_hs,    1);
        checkOutput("postrst_addr", hs_addr, 32'h20);
        checkOutput("postrst_data", hs_data, 32'h1001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
